title_screen_ctrl: RTL and testbench
====================================

// Module: title_screen_ctrl
// PURPOSE
//  Sequences the title screen ahead of the title sprite renderer.
//  - Slides the title from TITLE_Y_START down to TITLE_Y_FINAL, then blinks a "press start" prompt.
//  - On the start key, slides the title back up, pulses game_start and hands control to the game.
//  - Drives title_y_pos and the show_* enables consumed by the title/prompt sprite logic and the colour mapper.
// PARAMETERS
//  TITLE_Y_START  10'd0    title Y position off/at top; slide origin and exit target
//  TITLE_Y_FINAL  10'd80   resting title Y position
//  SLIDE_STEP     10'd4    pixels moved per frame tick (must be >0)
//  BLINK_FRAMES   8'd30    frame ticks per prompt on/off phase (must be >0)
//  START_KEY      8'h28    keycode that starts the game (Enter)
// PORTS
//  Clk          in   1   system clock
//  Reset        in   1   synchronous, active-high reset
//  frame_clk    in   1   per-frame signal from VGA controller (level, Clk-sampled)
//  keycode      in   8   current keyboard keycode, 0 = none
//  game_over    in   1   level/pulse from game logic; returns to title
//  title_y_pos  out  10  current title Y origin for sprite address calc
//  show_title   out  1   title sprite enable
//  show_prompt  out  1   "press start" sprite enable
//  game_start   out  1   one-Clk pulse when game begins
//  in_game      out  1   high while in GAME state
//  state        out  2   0 SLIDE_IN, 1 WAIT_KEY, 2 EXIT, 3 GAME
// BEHAVIOUR
//  - All outputs registered; all state updates on posedge Clk only.
//  - frame_clk_d <= frame_clk each cycle; tick = frame_clk & ~frame_clk_d (rising edge).
//  - Reset values: state=SLIDE_IN, title_y_pos=TITLE_Y_START, show_title=1, show_prompt=0,
//    game_start=0, in_game=0, frame_clk_d=0, blink_cnt=0, armed=0.
//  - Reset wins over every other event, including mid-slide and mid-game.
//  - Arithmetic: title_y_pos +/- SLIDE_STEP computed in 11 bits; saturate at FINAL/START; never wraps.
//  - armed: cleared on reset and on entering SLIDE_IN; set on any cycle keycode != START_KEY.
//    A held key never starts the game; it must be released and pressed again.
//  - SLIDE_IN:
//    - keycode==START_KEY (skip): next cycle title_y_pos=FINAL, show_prompt=1, blink_cnt=0, state=WAIT_KEY. Skip has priority over tick.
//    - else on tick: title_y_pos += STEP. If sum >= FINAL: title_y_pos=FINAL, show_prompt=1, blink_cnt=0, state=WAIT_KEY.
//  - WAIT_KEY:
//    - keycode==START_KEY && armed: show_prompt=0, state=EXIT. Has priority over tick; blink not advanced.
//    - else on tick: blink_cnt++. At blink_cnt==BLINK_FRAMES-1: blink_cnt=0 and toggle show_prompt.
//  - EXIT:
//    - on tick: title_y_pos -= STEP, saturating at START.
//    - When it reaches START: show_title=0, game_start=1 for exactly one Clk, in_game=1, state=GAME.
//    - Keys are ignored.
//  - GAME:
//    - game_start=0 after its single cycle.
//    - game_over==1: state=SLIDE_IN, title_y_pos=START, show_title=1, show_prompt=0, in_game=0, armed=0.
//    - game_over is ignored in all other states.
//  - Latency: key -> state change 1 Clk; final EXIT tick -> game_start high on the next Clk edge.
//  - A frame_clk held high produces one tick only. Ticks are unaffected by state transitions.
// TESTING (defaults; frame_clk driven as 1-cycle-high pulses, >=4 Clk apart)
//  1. Reset, then 20 ticks, keycode=0 -> title_y_pos 4,8,...,80; state=1 after 20th; show_prompt=1.
//  2. WAIT_KEY, 30 ticks -> show_prompt 1->0 on 30th tick; 60 ticks -> back to 1; blink_cnt never >29.
//  3. SLIDE_IN at y=40, keycode=8'h28 held -> y=80, state=1 next Clk; key still held 100 cycles -> stays 1;
//     release then press -> state=2.
//  4. EXIT from y=80, 20 ticks -> y steps to 0; game_start high exactly 1 Clk; in_game=1, show_title=0, state=3.
//  5. GAME, game_over=1 -> state=0, y=0, show_title=1, in_game=0; game_over pulsed in WAIT_KEY -> no effect.
//  6. Reset asserted mid-EXIT (y=36) and mid-GAME -> all outputs at reset values next Clk;
//     tick coincident with key in WAIT_KEY -> EXIT, blink_cnt unchanged.

Source files
------------

// File: rtl/title_screen_ctrl.sv
// Title screen sequencer: slides the title in, blinks the start prompt, slides the
// title out on a fresh start-key press, then holds in GAME until game_over.
module title_screen_ctrl #(
    parameter logic [9:0] TITLE_Y_START = 10'd0,
    parameter logic [9:0] TITLE_Y_FINAL = 10'd80,
    parameter logic [9:0] SLIDE_STEP    = 10'd4,
    parameter logic [7:0] BLINK_FRAMES  = 8'd30,
    parameter logic [7:0] START_KEY     = 8'h28
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       game_over,
    output logic [9:0] title_y_pos,
    output logic       show_title,
    output logic       show_prompt,
    output logic       game_start,
    output logic       in_game,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        SLIDE_IN = 2'd0,
        WAIT_KEY = 2'd1,
        EXIT     = 2'd2,
        GAME     = 2'd3
    } state_t;

    state_t     st_q, st_n;
    logic [9:0] y_q, y_n;
    logic       title_q, title_n;
    logic       prompt_q, prompt_n;
    logic       gs_q, gs_n;
    logic       ig_q, ig_n;
    logic [7:0] blink_q, blink_n;
    logic       armed_q, armed_n;
    logic       frame_clk_d;

    logic        tick;
    logic        key_start;
    logic [10:0] y_sum;
    logic [10:0] y_dif;
    logic        at_final;
    logic        at_start;

    assign tick      = frame_clk & ~frame_clk_d;
    assign key_start = (keycode == START_KEY);

    // 11-bit arithmetic so the slide saturates instead of wrapping
    assign y_sum    = {1'b0, y_q} + {1'b0, SLIDE_STEP};
    assign y_dif    = {1'b0, y_q} - {1'b0, SLIDE_STEP};
    assign at_final = (y_sum >= {1'b0, TITLE_Y_FINAL});
    assign at_start = y_dif[10] || (y_dif[9:0] <= TITLE_Y_START);

    always_comb begin
        st_n     = st_q;
        y_n      = y_q;
        title_n  = title_q;
        prompt_n = prompt_q;
        gs_n     = 1'b0;
        ig_n     = ig_q;
        blink_n  = blink_q;
        armed_n  = armed_q | ~key_start;

        case (st_q)
            SLIDE_IN: begin
                if (key_start) begin
                    // A skip consumes the press: the key must come up before it can start the game
                    y_n      = TITLE_Y_FINAL;
                    prompt_n = 1'b1;
                    blink_n  = 8'd0;
                    armed_n  = 1'b0;
                    st_n     = WAIT_KEY;
                end else if (tick) begin
                    if (at_final) begin
                        y_n      = TITLE_Y_FINAL;
                        prompt_n = 1'b1;
                        blink_n  = 8'd0;
                        st_n     = WAIT_KEY;
                    end else begin
                        y_n = y_sum[9:0];
                    end
                end
            end

            WAIT_KEY: begin
                if (key_start && armed_q) begin
                    prompt_n = 1'b0;
                    st_n     = EXIT;
                end else if (tick) begin
                    if (blink_q >= BLINK_FRAMES - 8'd1) begin
                        blink_n  = 8'd0;
                        prompt_n = ~prompt_q;
                    end else begin
                        blink_n = blink_q + 8'd1;
                    end
                end
            end

            EXIT: begin
                if ((tick && at_start) || (y_q == TITLE_Y_START)) begin
                    y_n     = TITLE_Y_START;
                    title_n = 1'b0;
                    gs_n    = 1'b1;
                    ig_n    = 1'b1;
                    st_n    = GAME;
                end else if (tick) begin
                    y_n = y_dif[9:0];
                end
            end

            GAME: begin
                if (game_over) begin
                    y_n      = TITLE_Y_START;
                    title_n  = 1'b1;
                    prompt_n = 1'b0;
                    ig_n     = 1'b0;
                    armed_n  = 1'b0;
                    st_n     = SLIDE_IN;
                end
            end

            default: st_n = SLIDE_IN;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            st_q        <= SLIDE_IN;
            y_q         <= TITLE_Y_START;
            title_q     <= 1'b1;
            prompt_q    <= 1'b0;
            gs_q        <= 1'b0;
            ig_q        <= 1'b0;
            blink_q     <= 8'd0;
            armed_q     <= 1'b0;
            frame_clk_d <= 1'b0;
        end else begin
            st_q        <= st_n;
            y_q         <= y_n;
            title_q     <= title_n;
            prompt_q    <= prompt_n;
            gs_q        <= gs_n;
            ig_q        <= ig_n;
            blink_q     <= blink_n;
            armed_q     <= armed_n;
            frame_clk_d <= frame_clk;
        end
    end

    assign title_y_pos = y_q;
    assign show_title  = title_q;
    assign show_prompt = prompt_q;
    assign game_start  = gs_q;
    assign in_game     = ig_q;
    assign state       = st_q;

endmodule

// File: tb/tb_title_screen_ctrl.sv
// Scoreboard bench for title_screen_ctrl: stimulus queues expected outputs per edge,
// a monitor pops and compares them just after each rising Clk edge.
module tb_title_screen_ctrl;

    logic       Clk, Reset, frame_clk, game_over;
    logic [7:0] keycode;
    logic [9:0] title_y_pos;
    logic       show_title, show_prompt, game_start, in_game;
    logic [1:0] state;

    title_screen_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
        .game_over(game_over), .title_y_pos(title_y_pos), .show_title(show_title),
        .show_prompt(show_prompt), .game_start(game_start), .in_game(in_game),
        .state(state)
    );

    typedef struct {
        int         due;
        string      name;
        logic [1:0] st;
        logic [9:0] y;
        logic       t, p, gs, ig;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    // hand-tracked expected outputs, updated by the stimulus before each edge
    logic [1:0] e_st;
    logic [9:0] e_y;
    logic       e_t, e_p, e_gs, e_ig;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                n_tests++;
                if (e.due != cyc || state !== e.st || title_y_pos !== e.y || show_title !== e.t ||
                    show_prompt !== e.p || game_start !== e.gs || in_game !== e.ig) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d due=%0d: got st=%0d y=%0d t=%b p=%b gs=%b ig=%b, want st=%0d y=%0d t=%b p=%b gs=%b ig=%b",
                             e.name, cyc, e.due, state, title_y_pos, show_title, show_prompt,
                             game_start, in_game, e.st, e.y, e.t, e.p, e.gs, e.ig);
                end
            end
        end
    end

    // push expectation for the coming edge, then move to the next falling edge
    task automatic adv(input string nm);
        exp_t e;
        e.due = cyc + 1; e.name = nm; e.st = e_st; e.y = e_y;
        e.t = e_t; e.p = e_p; e.gs = e_gs; e.ig = e_ig;
        sb.push_back(e);
        @(negedge Clk);
    endtask

    // one-cycle frame_clk pulse followed by 3 quiet cycles; e_* hold the post-tick values
    task automatic do_tick(input string nm);
        frame_clk = 1'b1;
        adv(nm);
        frame_clk = 1'b0;
        e_gs = 1'b0;
        repeat (3) adv(nm);
    endtask

    task automatic set_reset_exp();
        e_st = 2'd0; e_y = 10'd0; e_t = 1'b1; e_p = 1'b0; e_gs = 1'b0; e_ig = 1'b0;
    endtask

    task automatic slide_to_game();
        keycode = 8'h00;
        for (int i = 1; i <= 20; i++) begin
            e_y = 10'(4 * i);
            if (i == 20) begin e_st = 2'd1; e_p = 1'b1; end
            do_tick("slide_in2");
        end
        keycode = 8'h28; e_st = 2'd2; e_p = 1'b0;
        adv("press2");
        keycode = 8'h00;
        for (int i = 1; i <= 20; i++) begin
            e_y = 10'(80 - 4 * i);
            if (i == 20) begin e_st = 2'd3; e_t = 1'b0; e_gs = 1'b1; e_ig = 1'b1; end
            do_tick("exit2");
        end
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; keycode = 8'h00; game_over = 1'b0;
        @(negedge Clk);
        set_reset_exp();
        adv("reset");
        frame_clk = 1'b1;
        adv("reset_tick");
        frame_clk = 1'b0;
        Reset = 1'b0;
        adv("idle");

        // slide in from 0 to 80
        for (int i = 1; i <= 20; i++) begin
            e_y = 10'(4 * i);
            if (i == 20) begin e_st = 2'd1; e_p = 1'b1; end
            do_tick("slide_in");
        end

        // blink: toggles on the 30th and 60th tick
        for (int i = 1; i <= 60; i++) begin
            if (i == 30) e_p = 1'b0;
            if (i == 60) e_p = 1'b1;
            do_tick("blink");
        end
        for (int i = 1; i <= 5; i++) do_tick("blink_more");

        // tick coincident with a fresh start key: key wins, title not moved yet
        keycode = 8'h28; frame_clk = 1'b1; e_st = 2'd2; e_p = 1'b0;
        adv("key_and_tick");
        frame_clk = 1'b0; keycode = 8'h00;
        adv("exit_hold");

        // exit 80 -> 0; key presses ignored in EXIT
        for (int i = 1; i <= 20; i++) begin
            if (i == 5) keycode = 8'h28;
            if (i == 7) keycode = 8'h00;
            e_y = 10'(80 - 4 * i);
            if (i == 20) begin e_st = 2'd3; e_t = 1'b0; e_gs = 1'b1; e_ig = 1'b1; end
            do_tick("exit");
        end
        repeat (3) adv("game_hold");

        // game_over returns to title
        game_over = 1'b1;
        set_reset_exp();
        adv("game_over");
        game_over = 1'b0;
        adv("after_over");

        // slide to 40 then skip with held key
        for (int i = 1; i <= 10; i++) begin
            e_y = 10'(4 * i);
            do_tick("slide_to40");
        end
        keycode = 8'h28; e_y = 10'd80; e_st = 2'd1; e_p = 1'b1;
        adv("skip");
        for (int i = 0; i < 100; i++) adv("held_key");
        keycode = 8'h00; game_over = 1'b1;
        adv("wait_game_over");
        game_over = 1'b0; keycode = 8'h28; e_st = 2'd2; e_p = 1'b0;
        adv("repress");
        keycode = 8'h00;

        // reset mid-exit at y=36
        for (int i = 1; i <= 11; i++) begin
            e_y = 10'(80 - 4 * i);
            do_tick("exit_to36");
        end
        Reset = 1'b1;
        set_reset_exp();
        adv("reset_mid_exit");
        Reset = 1'b0;
        adv("post_reset1");

        // reset mid-game
        slide_to_game();
        adv("game_hold2");
        Reset = 1'b1;
        set_reset_exp();
        adv("reset_mid_game");
        Reset = 1'b0;
        adv("post_reset2");

        // frame_clk held high yields one tick only
        frame_clk = 1'b1; e_y = 10'd4;
        repeat (6) adv("held_frame");
        frame_clk = 1'b0;
        adv("held_frame_low");

        @(negedge Clk);
        @(negedge Clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
